mips_mem_arbiter: RTL and testbench

- Sequences the single-cycle Harvard MIPS core onto one shared, stallable memory port (Avalon-style, waitrequest handshake) for the bus-based CPU variant.
- Per instruction: fetches the instruction, lets the core decode it from a latched copy, performs at most one data read or write, then pulses the core's clk_enable for exactly one cycle so the core commits.
- Sits between mips_cpu_harvard and the unified memory; owns the core's clk_enable.

---
 rtl/mips_bus_pkg.sv | 19 +
 rtl/mips_bus_wait_timer.sv | 34 +++
 rtl/mips_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the bus-based MIPS memory arbiter.
// The state enum is the arbiter's sequencing order for one instruction.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_COMMIT,
        S_HALT,
        S_ERROR
    } arb_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] WORD_ALIGN_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/mips_bus_wait_timer.sv
// Counts consecutive stalled strobe cycles and flags a timeout on the stall
// that would take the count past MAX_WAIT.
module mips_bus_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_stall,
    input  logic i_done,
    output logic o_timeout
);

    localparam int              CW    = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0]   LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (i_done) begin
                r_count <= '0;
            end else if (i_stall && !o_timeout) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // The stall that finds the counter already at the limit is the one too many.
    assign o_timeout = i_stall && (r_count == LIMIT);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Sequences the single-cycle Harvard core onto one shared stallable memory port:
// fetch, decode, optional data access, then a one-cycle commit pulse.
module mips_mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error,
    output logic        halted
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_writedata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic        r_clk_en;
    logic        r_bus_error;
    logic        r_halted;
    logic        r_first_fetch;

    logic [31:0] w_mem_address;
    logic [31:0] w_mem_writedata;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_clk_en;
    logic        w_bus_error;
    logic        w_halted;
    logic        w_entering;
    logic        w_strobe;
    logic        w_stall;
    logic        w_done;
    logic        w_timeout;

    assign w_strobe = r_mem_read | r_mem_write;
    assign w_stall  = w_strobe & mem_waitrequest;
    assign w_done   = w_strobe & ~mem_waitrequest;

    mips_bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (enable),
        .i_stall   (w_stall),
        .i_done    (w_done),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (w_timeout)   w_next = S_ERROR;
                else if (w_done) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (data_write)     w_next = S_WRITE;
                else if (data_read) w_next = S_READ;
                else                w_next = S_COMMIT;
            end
            S_READ, S_WRITE: begin
                if (w_timeout)   w_next = S_ERROR;
                else if (w_done) w_next = S_COMMIT;
            end
            S_COMMIT: w_next = cpu_active ? S_FETCH : S_HALT;
            S_HALT:   w_next = S_HALT;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state; address and write data are
    // captured only on entry so they cannot move while the slave stalls.
    always_comb begin
        w_entering      = (w_next != r_state);
        w_mem_address   = r_mem_address;
        w_mem_writedata = r_mem_writedata;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_clk_en        = 1'b0;
        w_bus_error     = 1'b0;
        w_halted        = 1'b0;
        case (w_next)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (w_entering) begin
                    w_mem_address = r_first_fetch ? (RESET_VECTOR & WORD_ALIGN_MASK)
                                                  : (instr_address & WORD_ALIGN_MASK);
                end
            end
            S_READ: begin
                w_mem_read = 1'b1;
                if (w_entering) w_mem_address = data_address & WORD_ALIGN_MASK;
            end
            S_WRITE: begin
                w_mem_write = 1'b1;
                if (w_entering) begin
                    w_mem_address   = data_address & WORD_ALIGN_MASK;
                    w_mem_writedata = data_writedata;
                end
            end
            S_COMMIT: w_clk_en    = 1'b1;
            S_HALT:   w_halted    = 1'b1;
            S_ERROR:  w_bus_error = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_instr         <= '0;
            r_data          <= '0;
            r_clk_en        <= 1'b0;
            r_bus_error     <= 1'b0;
            r_halted        <= 1'b0;
            r_first_fetch   <= 1'b1;
        end else if (enable) begin
            r_state         <= w_next;
            r_mem_address   <= w_mem_address;
            r_mem_writedata <= w_mem_writedata;
            r_mem_read      <= w_mem_read;
            r_mem_write     <= w_mem_write;
            r_clk_en        <= w_clk_en;
            r_bus_error     <= w_bus_error;
            r_halted        <= w_halted;
            if (r_state == S_FETCH) r_first_fetch <= 1'b0;
            if (r_state == S_FETCH && w_done) r_instr <= mem_readdata;
            if (r_state == S_READ && w_done)  r_data  <= mem_readdata;
        end
    end

    assign instr_readdata = r_instr;
    assign data_readdata  = r_data;
    // A frozen COMMIT keeps its flag but must not let the core advance.
    assign cpu_clk_enable = r_clk_en & enable;
    assign mem_address    = r_mem_address;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign bus_error      = r_bus_error;
    assign halted         = r_halted;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_mips_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        cpu_clk_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        bus_error;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic        s_read, s_write, s_clk_en, s_bus_error, s_halted, s_wait;
    logic [31:0] s_addr, s_wdata, s_instr, s_data;

    mips_mem_arbiter #(
        .RESET_VECTOR (32'hBFC0_0000),
        .MAX_WAIT     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .cpu_active      (cpu_active),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .cpu_clk_enable  (cpu_clk_enable),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .bus_error       (bus_error),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: present the slave response, sample at the falling edge,
    // then return 1ns after the next rising edge.
    task automatic cycle(input logic wr, input logic [31:0] rd);
        mem_waitrequest = wr;
        mem_readdata    = rd;
        @(negedge clk);
        s_read      = mem_read;
        s_write     = mem_write;
        s_addr      = mem_address;
        s_wdata     = mem_writedata;
        s_clk_en    = cpu_clk_enable;
        s_bus_error = bus_error;
        s_halted    = halted;
        s_instr     = instr_readdata;
        s_data      = data_readdata;
        s_wait      = mem_waitrequest;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b1, 32'h0);
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL reset_strobes: got r=%0b w=%0b want 0 0", s_read, s_write); end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", s_addr); end
        checks++; if (s_clk_en !== 1'b0 || s_bus_error !== 1'b0 || s_halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got ce=%0b be=%0b h=%0b want 0 0 0", s_clk_en, s_bus_error, s_halted); end
        checks++; if (s_instr !== 32'h0 || s_data !== 32'h0) begin errors++; $display("FAIL reset_latches: got i=%h d=%h want 0 0", s_instr, s_data); end
    endtask

    task automatic test_alu();
        int pulses;
        pulses = 0;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'h2402_0005);                // FETCH, zero wait
        checks++; if (s_read !== 1'b1 || s_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL alu_fetch: got r=%0b a=%h want 1 bfc00000", s_read, s_addr); end
        pulses += int'(s_clk_en);
        instr_address = 32'hBFC0_0004;
        cycle(1'b0, 32'h0);                        // DECODE
        checks++; if (s_instr !== 32'h2402_0005) begin errors++; $display("FAIL alu_instr_latch: got %h want 24020005", s_instr); end
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL alu_decode_idle_bus: got r=%0b w=%0b want 0 0", s_read, s_write); end
        pulses += int'(s_clk_en);
        cycle(1'b0, 32'h0);                        // COMMIT, third cycle of the instruction
        checks++; if (s_clk_en !== 1'b1 || s_read !== 1'b0) begin errors++; $display("FAIL alu_commit: got ce=%0b r=%0b want 1 0", s_clk_en, s_read); end
        pulses += int'(s_clk_en);
        cycle(1'b1, 32'h0);                        // next FETCH
        checks++; if (s_read !== 1'b1 || s_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL alu_next_fetch: got r=%0b a=%h want 1 bfc00004", s_read, s_addr); end
        pulses += int'(s_clk_en);
        checks++; if (pulses != 1) begin errors++; $display("FAIL alu_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_load_wait();
        int stable;
        stable = 0;
        instr_address = 32'hBFC0_0000;
        data_address  = 32'h0000_1006;
        data_read     = 1'b1;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'h8C82_0000);                // FETCH
        cycle(1'b0, 32'h0);                        // DECODE
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL load_decode_read: got %0b want 0", s_read); end
        cycle(1'b1, 32'h0);
        if (s_read === 1'b1 && s_write === 1'b0 && s_addr === 32'h0000_1004) stable++;
        cycle(1'b1, 32'h0);
        if (s_read === 1'b1 && s_write === 1'b0 && s_addr === 32'h0000_1004) stable++;
        cycle(1'b0, 32'hDEAD_BEEF);
        if (s_read === 1'b1 && s_write === 1'b0 && s_addr === 32'h0000_1004) stable++;
        checks++; if (s_data !== 32'h0) begin errors++; $display("FAIL load_early_latch: got %h want 00000000", s_data); end
        checks++; if (stable != 3) begin errors++; $display("FAIL load_addr_stable: got %0d cycles want 3", stable); end
        cycle(1'b0, 32'h0);                        // COMMIT
        checks++; if (s_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", s_data); end
        checks++; if (s_clk_en !== 1'b1 || s_read !== 1'b0) begin errors++; $display("FAIL load_commit: got ce=%0b r=%0b want 1 0", s_clk_en, s_read); end
        data_read = 1'b0;
    endtask

    task automatic test_store_both();
        int xfers, reads, pulses;
        xfers = 0; reads = 0; pulses = 0;
        instr_address  = 32'hBFC0_0000;
        data_address   = 32'h0000_2008;
        data_writedata = 32'hCAFE_F00D;
        data_read      = 1'b1;
        data_write     = 1'b1;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'hAC83_0000);                // FETCH
        for (int i = 0; i < 4; i++) begin          // DECODE, WRITE x2, COMMIT
            cycle((i == 1) ? 1'b1 : 1'b0, 32'h0);
            if (s_write === 1'b1 && s_wait === 1'b0) xfers++;
            if (s_read === 1'b1) reads++;
            pulses += int'(s_clk_en);
            if (i == 1) begin
                checks++; if (s_addr !== 32'h0000_2008 || s_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_bus: got a=%h d=%h want 00002008 cafef00d", s_addr, s_wdata); end
            end
        end
        checks++; if (xfers != 1) begin errors++; $display("FAIL store_xfers: got %0d want 1", xfers); end
        checks++; if (reads != 0) begin errors++; $display("FAIL store_reads: got %0d want 0", reads); end
        checks++; if (pulses != 1 || s_clk_en !== 1'b1) begin errors++; $display("FAIL store_commit: got pulses=%0d last=%0b want 1 1", pulses, s_clk_en); end
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic test_timeout();
        int strobes, pulses, early_err;
        strobes = 0; pulses = 0; early_err = 0;
        instr_address = 32'hBFC0_0000;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h0);
            strobes += int'(s_read);
            early_err += int'(s_bus_error);
            pulses += int'(s_clk_en);
        end
        checks++; if (strobes != 5 || early_err != 0) begin errors++; $display("FAIL timeout_stalls: got strobes=%0d err=%0d want 5 0", strobes, early_err); end
        cycle(1'b1, 32'h0);
        checks++; if (s_bus_error !== 1'b1 || s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL timeout_error: got be=%0b r=%0b w=%0b want 1 0 0", s_bus_error, s_read, s_write); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            pulses += int'(s_clk_en);
            strobes += int'(s_read | s_write);
        end
        checks++; if (pulses != 0 || strobes != 5 || s_bus_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got pulses=%0d strobes=%0d be=%0b want 0 5 1", pulses, strobes, s_bus_error); end
        do_reset();
        cycle(1'b1, 32'h0);
        checks++; if (s_bus_error !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got %0b want 0", s_bus_error); end
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        pulses = 0;
        instr_address = 32'hBFC0_0000;
        data_address  = 32'h0000_3000;
        data_read     = 1'b1;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'h8C82_0000);                // FETCH
        cycle(1'b0, 32'h0);                        // DECODE
        cycle(1'b1, 32'h0);                        // READ, stalled
        checks++; if (s_read !== 1'b1 || s_addr !== 32'h0000_3000) begin errors++; $display("FAIL midrst_read: got r=%0b a=%h want 1 00003000", s_read, s_addr); end
        reset = 1'b0;
        cycle(1'b1, 32'h0);
        pulses += int'(s_clk_en);
        reset = 1'b1;
        data_read = 1'b0;
        cycle(1'b0, 32'h2402_0005);                // IDLE after reset
        pulses += int'(s_clk_en);
        checks++; if (s_read !== 1'b0 || s_addr !== 32'h0 || s_instr !== 32'h0 || s_data !== 32'h0) begin errors++; $display("FAIL midrst_cleared: got r=%0b a=%h i=%h d=%h want all 0", s_read, s_addr, s_instr, s_data); end
        cycle(1'b0, 32'h2402_0005);                // FETCH restart
        pulses += int'(s_clk_en);
        checks++; if (s_read !== 1'b1 || s_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL midrst_refetch: got r=%0b a=%h want 1 bfc00000", s_read, s_addr); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_commit: got %0d want 0", pulses); end
    endtask

    task automatic test_enable_freeze();
        int frozen_pulses;
        frozen_pulses = 0;
        instr_address = 32'hBFC0_0000;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'h2402_0005);                // FETCH
        cycle(1'b0, 32'h0);                        // DECODE; returns just inside COMMIT
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            frozen_pulses += int'(s_clk_en);
        end
        checks++; if (frozen_pulses != 0) begin errors++; $display("FAIL freeze_no_pulse: got %0d want 0", frozen_pulses); end
        enable = 1'b1;
        cycle(1'b0, 32'h0);
        checks++; if (s_clk_en !== 1'b1) begin errors++; $display("FAIL freeze_resume_pulse: got %0b want 1", s_clk_en); end
        cycle(1'b1, 32'h0);
        checks++; if (s_clk_en !== 1'b0 || s_read !== 1'b1) begin errors++; $display("FAIL freeze_after: got ce=%0b r=%0b want 0 1", s_clk_en, s_read); end
    endtask

    task automatic test_halt();
        int halt_cycles, strobes, pulses;
        halt_cycles = 0; strobes = 0; pulses = 0;
        instr_address = 32'hBFC0_0000;
        cpu_active    = 1'b0;
        do_reset();
        cycle(1'b1, 32'h0);                        // IDLE
        cycle(1'b0, 32'h0000_000C);                // FETCH
        cycle(1'b0, 32'h0);                        // DECODE
        cycle(1'b0, 32'h0);                        // COMMIT
        checks++; if (s_clk_en !== 1'b1 || s_halted !== 1'b0) begin errors++; $display("FAIL halt_commit: got ce=%0b h=%0b want 1 0", s_clk_en, s_halted); end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            halt_cycles += int'(s_halted);
            strobes += int'(s_read | s_write);
            pulses += int'(s_clk_en);
        end
        checks++; if (halt_cycles != 20) begin errors++; $display("FAIL halt_flag: got %0d cycles want 20", halt_cycles); end
        checks++; if (strobes != 0 || pulses != 0) begin errors++; $display("FAIL halt_quiet: got strobes=%0d pulses=%0d want 0 0", strobes, pulses); end
        cpu_active = 1'b1;
    endtask

    initial begin
        reset           = 1'b0;
        enable          = 1'b1;
        cpu_active      = 1'b1;
        instr_address   = 32'hBFC0_0000;
        data_address    = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_writedata  = 32'h0;
        mem_readdata    = 32'h0;
        mem_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_load_wait();
        test_store_both();
        test_timeout();
        test_reset_mid_read();
        test_enable_freeze();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
